// File: rtl/register_bank_m.sv
// register_bank_m: CPU register bank with multi-port byte/word reads, byte-lane
// writes, an internal auto-incrementing PC and a shadow-bank context engine
// that saves or restores the whole active set one entry per cycle.
module register_bank_m #(
  parameter int                   REG_WIDTH = 16,
  parameter int                   REG_COUNT = 8,
  parameter int                   RD_PORTS  = 2,
  parameter int                   BANKS     = 2,
  parameter int                   PC_ADDR   = REG_COUNT - 1,
  parameter int                   PC_STEP   = 2,
  parameter logic [REG_WIDTH-1:0] RESET_PC  = '0,
  parameter int                   BYPASS    = 1,
  localparam int                  HW        = REG_WIDTH / 2,
  localparam int                  AW        = $clog2(REG_COUNT),
  localparam int                  BW        = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [REG_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr  [RD_PORTS],
  input  logic                 rd_size  [RD_PORTS],
  output logic [REG_WIDTH-1:0] rd_data  [RD_PORTS],
  input  logic                 pc_inc,
  output logic [REG_WIDTH-1:0] pc_out,
  input  logic                 ctx_req,
  input  logic                 ctx_op,
  input  logic [BW-1:0]        ctx_bank,
  output logic                 ctx_busy,
  output logic                 ctx_done
);

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  localparam logic [AW-1:0] PC_IDX   = AW'(PC_ADDR);
  localparam logic [AW-1:0] LAST_IDX = AW'(REG_COUNT - 1);

  logic [REG_WIDTH-1:0] act [REG_COUNT];
  logic [REG_WIDTH-1:0] shd [BANKS][REG_COUNT];

  state_t               state;
  logic [AW-1:0]        idx;
  logic                 op_q;     // 0 = save, 1 = restore
  logic [BW-1:0]        bank_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pc_written;
  logic [REG_WIDTH-1:0] src [RD_PORTS];

  // A CPU write that touches the PC in any lane overrides that cycle's increment.
  assign pc_written = (wr_addr == PC_IDX) && (|wr_en);

  // Context FSM plus all storage updates: copy engine while busy, CPU writes and PC otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: both arrays are cleared explicitly because the restore path must
      // see defined zeros; this forbids mapping them onto reset-less RAM macros.
      for (int i = 0; i < REG_COUNT; i++) begin
        act[i] <= (i == PC_ADDR) ? RESET_PC : '0;
        for (int b = 0; b < BANKS; b++) shd[b][i] <= '0;
      end
      state  <= IDLE;
      idx    <= '0;
      op_q   <= 1'b0;
      bank_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values,
      // e.g. the save path reads act[idx] before any same-edge update lands.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ctx_req) begin
            op_q   <= ctx_op;
            bank_q <= BW'(int'(ctx_bank) % BANKS);
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= COPY;
          end
        end
        COPY: begin
          if (idx == LAST_IDX) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (state == COPY) begin
        if (op_q) act[idx]         <= shd[bank_q][idx];
        else      shd[bank_q][idx] <= act[idx];
      end else begin
        if (wr_en[0]) act[wr_addr][HW-1:0]         <= wr_data[HW-1:0];
        if (wr_en[1]) act[wr_addr][REG_WIDTH-1:HW] <= wr_data[REG_WIDTH-1:HW];
        if (pc_inc && !pc_written)
          act[PC_ADDR] <= act[PC_ADDR] + REG_WIDTH'(PC_STEP);
      end
    end
  end

  // Combinational read ports with optional same-cycle write bypass and byte sign-extension.
  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      // NOTE: src[p] is assigned unconditionally before the conditional lane
      // overrides so no path leaves it unassigned and no latch is inferred.
      src[p] = act[rd_addr[p]];
      if ((BYPASS != 0) && !busy_q && (wr_addr == rd_addr[p])) begin
        if (wr_en[0]) src[p][HW-1:0]         = wr_data[HW-1:0];
        if (wr_en[1]) src[p][REG_WIDTH-1:HW] = wr_data[REG_WIDTH-1:HW];
      end
      rd_data[p] = rd_size[p] ? src[p] : {{HW{src[p][HW-1]}}, src[p][HW-1:0]};
    end
  end

  assign pc_out   = act[PC_ADDR];
  assign ctx_busy = busy_q;
  assign ctx_done = done_q;

endmodule

// File: tb/tb_register_bank_m.sv
// Scoreboard bench for register_bank_m: expected values are queued when
// stimulus is applied and popped when the corresponding output is sampled.
module tb_register_bank_m;
  localparam int W = 16, N = 8, P = 2, B = 2, AW = 3, BW = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [AW-1:0] rd_addr [P];
  logic          rd_size [P];
  logic [W-1:0]  rd_data [P];
  logic          pc_inc;
  logic [W-1:0]  pc_out;
  logic          ctx_req;
  logic          ctx_op;
  logic [BW-1:0] ctx_bank;
  logic          ctx_busy;
  logic          ctx_done;

  int total  = 0;
  int passed = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] model [N];

  always #5 clk = ~clk;

  register_bank_m #(.REG_WIDTH(W), .REG_COUNT(N), .RD_PORTS(P), .BANKS(B)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_size(rd_size), .rd_data(rd_data), .pc_inc(pc_inc),
    .pc_out(pc_out), .ctx_req(ctx_req), .ctx_op(ctx_op), .ctx_bank(ctx_bank),
    .ctx_busy(ctx_busy), .ctx_done(ctx_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 2'b00; wr_addr = '0; wr_data = '0; pc_inc = 1'b0;
    ctx_req = 1'b0; ctx_op = 1'b0; ctx_bank = '0;
    for (int p = 0; p < P; p++) begin rd_addr[p] = '0; rd_size[p] = 1'b1; end
  endtask

  // Drives one CPU write for a cycle and mirrors the lane update into the model.
  task automatic cpu_write(input logic [AW-1:0] a, input logic [1:0] en, input logic [W-1:0] d);
    wr_addr = a; wr_en = en; wr_data = d;
    tick();
    wr_en = 2'b00;
    if (en[0]) model[a][7:0]  = d[7:0];
    if (en[1]) model[a][15:8] = d[15:8];
  endtask

  // Issues a context request and waits (bounded) for ctx_done; cycles counts edges from the request edge.
  task automatic run_ctx(input logic op, input logic [BW-1:0] bank, output int cycles);
    ctx_req = 1'b1; ctx_op = op; ctx_bank = bank;
    tick();
    ctx_req = 1'b0;
    cycles = 1;
    while (!ctx_done && cycles < 20) begin tick(); cycles++; end
  endtask

  function automatic logic [W-1:0] sext8(input logic [W-1:0] v);
    return {{8{v[7]}}, v[7:0]};
  endfunction

  task automatic test_reset();
    logic [W-1:0] e;
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) model[i] = '0;
    for (int i = 0; i < N; i++) begin
      rd_addr[0] = AW'(i); rd_addr[1] = AW'(i); rd_size[1] = 1'b0;
      exp_q.push_back(model[i]); exp_q.push_back(sext8(model[i]));
      #1;
      e = exp_q.pop_front(); total++;
      if (rd_data[0] !== e) $display("FAIL reset_rd0[%0d]: got %h want %h", i, rd_data[0], e); else passed++;
      e = exp_q.pop_front(); total++;
      if (rd_data[1] !== e) $display("FAIL reset_rd1[%0d]: got %h want %h", i, rd_data[1], e); else passed++;
    end
    rd_size[1] = 1'b1;
    exp_q.push_back(16'h0000); exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    e = exp_q.pop_front(); total++;
    if (pc_out !== e) $display("FAIL reset_pc: got %h want %h", pc_out, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (W'(ctx_busy) !== e) $display("FAIL reset_busy: got %0d want %0d", ctx_busy, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (W'(ctx_done) !== e) $display("FAIL reset_done: got %0d want %0d", ctx_done, e); else passed++;
  endtask

  task automatic test_pc_inc();
    logic [W-1:0] e;
    pc_inc = 1'b1;
    tick(); tick(); tick();
    pc_inc = 1'b0;
    model[7] = model[7] + 16'd6;
    exp_q.push_back(16'd6); exp_q.push_back(model[7]);
    rd_addr[1] = 3'd7; rd_size[1] = 1'b1;
    #1;
    e = exp_q.pop_front(); total++;
    if (pc_out !== e) $display("FAIL pc_inc3: got %h want %h", pc_out, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (rd_data[1] !== e) $display("FAIL pc_read_port: got %h want %h", rd_data[1], e); else passed++;
  endtask

  task automatic test_byte_lanes();
    logic [W-1:0] e;
    cpu_write(3'd3, 2'b01, 16'hA5F0);
    rd_addr[0] = 3'd3; rd_size[0] = 1'b1;
    exp_q.push_back(16'h00F0);
    #1;
    e = exp_q.pop_front(); total++;
    if (rd_data[0] !== e) $display("FAIL lane_low: got %h want %h", rd_data[0], e); else passed++;
    cpu_write(3'd3, 2'b10, 16'h12AB);
    rd_addr[1] = 3'd3; rd_size[1] = 1'b0;
    exp_q.push_back(16'h12F0); exp_q.push_back(16'hFFF0);
    #1;
    e = exp_q.pop_front(); total++;
    if (rd_data[0] !== e) $display("FAIL lane_high: got %h want %h", rd_data[0], e); else passed++;
    e = exp_q.pop_front(); total++;
    if (rd_data[1] !== e) $display("FAIL byte_sext: got %h want %h", rd_data[1], e); else passed++;
    rd_size[1] = 1'b1;
  endtask

  task automatic test_bypass();
    logic [W-1:0] e;
    // Full-word bypass on port 0; port 1 reads an unrelated register.
    wr_addr = 3'd2; wr_en = 2'b11; wr_data = 16'h1234;
    rd_addr[0] = 3'd2; rd_size[0] = 1'b1; rd_addr[1] = 3'd3; rd_size[1] = 1'b1;
    exp_q.push_back(16'h1234); exp_q.push_back(model[3]);
    #1;
    e = exp_q.pop_front(); total++;
    if (rd_data[0] !== e) $display("FAIL bypass_word: got %h want %h", rd_data[0], e); else passed++;
    e = exp_q.pop_front(); total++;
    if (rd_data[1] !== e) $display("FAIL bypass_other: got %h want %h", rd_data[1], e); else passed++;
    tick();
    wr_en = 2'b00; model[2] = 16'h1234;
    // Low-lane bypass seen as word on port 0 and as sign-extended byte on port 1.
    wr_addr = 3'd3; wr_en = 2'b01; wr_data = 16'h0077;
    rd_addr[0] = 3'd3; rd_size[0] = 1'b1; rd_addr[1] = 3'd3; rd_size[1] = 1'b0;
    exp_q.push_back({model[3][15:8], 8'h77}); exp_q.push_back(16'h0077);
    #1;
    e = exp_q.pop_front(); total++;
    if (rd_data[0] !== e) $display("FAIL bypass_lane: got %h want %h", rd_data[0], e); else passed++;
    e = exp_q.pop_front(); total++;
    if (rd_data[1] !== e) $display("FAIL bypass_byte: got %h want %h", rd_data[1], e); else passed++;
    tick();
    wr_en = 2'b00; model[3][7:0] = 8'h77; rd_size[1] = 1'b1;
    // PC write beats pc_inc in the same cycle.
    pc_inc = 1'b1;
    cpu_write(3'd7, 2'b11, 16'h0100);
    pc_inc = 1'b0;
    exp_q.push_back(16'h0100);
    e = exp_q.pop_front(); total++;
    if (pc_out !== e) $display("FAIL pc_write_prio: got %h want %h", pc_out, e); else passed++;
  endtask

  task automatic test_context();
    logic [W-1:0] e;
    logic [W-1:0] saved [N];
    int c;
    for (int i = 0; i < N; i++) saved[i] = model[i];
    run_ctx(1'b0, 1'b1, c);
    exp_q.push_back(16'd9); exp_q.push_back(16'd0);
    e = exp_q.pop_front(); total++;
    if (W'(c) !== e) $display("FAIL save_latency: got %0d want %0d", c, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (W'(ctx_busy) !== e) $display("FAIL save_done_busy: got %0d want %0d", ctx_busy, e); else passed++;
    tick();
    for (int i = 0; i < N - 1; i++) cpu_write(AW'(i), 2'b11, 16'hFFFF);
    cpu_write(3'd7, 2'b11, 16'h5555);
    rd_addr[0] = 3'd0; rd_size[0] = 1'b1;
    exp_q.push_back(16'hFFFF);
    #1;
    e = exp_q.pop_front(); total++;
    if (rd_data[0] !== e) $display("FAIL overwrite_r0: got %h want %h", rd_data[0], e); else passed++;
    run_ctx(1'b1, 1'b1, c);
    exp_q.push_back(16'd9);
    e = exp_q.pop_front(); total++;
    if (W'(c) !== e) $display("FAIL restore_latency: got %0d want %0d", c, e); else passed++;
    for (int i = 0; i < N; i++) model[i] = saved[i];
    for (int i = 0; i < N; i++) begin
      rd_addr[0] = AW'(i);
      exp_q.push_back(model[i]);
      #1;
      e = exp_q.pop_front(); total++;
      if (rd_data[0] !== e) $display("FAIL restore_r%0d: got %h want %h", i, rd_data[0], e); else passed++;
    end
    exp_q.push_back(16'h0100);
    e = exp_q.pop_front(); total++;
    if (pc_out !== e) $display("FAIL restore_pc: got %h want %h", pc_out, e); else passed++;
    tick();
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] e;
    int c;
    ctx_req = 1'b1; ctx_op = 1'b0; ctx_bank = 1'b0;
    tick();
    // Everything below must be ignored while the save runs.
    ctx_op = 1'b1; ctx_bank = 1'b1;
    wr_en = 2'b11; wr_addr = 3'd1; wr_data = 16'hBEEF; pc_inc = 1'b1;
    rd_addr[0] = 3'd1; rd_size[0] = 1'b1;
    exp_q.push_back(16'd1); exp_q.push_back(model[1]);
    #1;
    e = exp_q.pop_front(); total++;
    if (W'(ctx_busy) !== e) $display("FAIL busy_set: got %0d want %0d", ctx_busy, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (rd_data[0] !== e) $display("FAIL busy_no_bypass: got %h want %h", rd_data[0], e); else passed++;
    c = 1;
    while (!ctx_done && c < 20) begin tick(); c++; end
    idle_inputs();
    tick();
    exp_q.push_back(16'd9); exp_q.push_back(16'd0); exp_q.push_back(16'd0);
    exp_q.push_back(model[1]); exp_q.push_back(model[7]);
    rd_addr[0] = 3'd1;
    #1;
    e = exp_q.pop_front(); total++;
    if (W'(c) !== e) $display("FAIL busy_latency: got %0d want %0d", c, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (W'(ctx_busy) !== e) $display("FAIL no_second_op: got %0d want %0d", ctx_busy, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (W'(ctx_done) !== e) $display("FAIL done_one_cycle: got %0d want %0d", ctx_done, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (rd_data[0] !== e) $display("FAIL busy_write_dropped: got %h want %h", rd_data[0], e); else passed++;
    e = exp_q.pop_front(); total++;
    if (pc_out !== e) $display("FAIL busy_pc_held: got %h want %h", pc_out, e); else passed++;
  endtask

  task automatic test_reset_mid_copy();
    logic [W-1:0] e;
    int done_seen;
    ctx_req = 1'b1; ctx_op = 1'b1; ctx_bank = 1'b1;
    tick();
    ctx_req = 1'b0;
    tick(); tick(); tick(); tick();   // copy index is now 4
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) model[i] = '0;
    exp_q.push_back(16'd0); exp_q.push_back(16'd0); exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); total++;
    if (W'(ctx_busy) !== e) $display("FAIL midrst_busy: got %0d want %0d", ctx_busy, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (W'(ctx_done) !== e) $display("FAIL midrst_done: got %0d want %0d", ctx_done, e); else passed++;
    e = exp_q.pop_front(); total++;
    if (pc_out !== e) $display("FAIL midrst_pc: got %h want %h", pc_out, e); else passed++;
    for (int i = 0; i < N; i++) begin
      rd_addr[0] = AW'(i);
      exp_q.push_back(model[i]);
      #1;
      e = exp_q.pop_front(); total++;
      if (rd_data[0] !== e) $display("FAIL midrst_r%0d: got %h want %h", i, rd_data[0], e); else passed++;
    end
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin tick(); if (ctx_done) done_seen++; end
    exp_q.push_back(16'd0);
    e = exp_q.pop_front(); total++;
    if (W'(done_seen) !== e) $display("FAIL midrst_no_done: got %0d want %0d", done_seen, e); else passed++;
  endtask

  task automatic test_pc_wrap();
    logic [W-1:0] e;
    cpu_write(3'd7, 2'b11, 16'hFFFE);
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    model[7] = model[7] + 16'd2;
    exp_q.push_back(16'h0000);
    e = exp_q.pop_front(); total++;
    if (pc_out !== e) $display("FAIL pc_wrap: got %h want %h", pc_out, e); else passed++;
  endtask

  initial begin
    test_reset();
    test_pc_inc();
    test_byte_lanes();
    test_bypass();
    test_context();
    test_busy_ignore();
    test_reset_mid_copy();
    test_pc_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/register_bank_m.md
# register_bank_m

Parametrised CPU register bank with N read ports, byte-lane writes and per-port byte/word read sizing. It holds an internal program counter with auto-increment and same-cycle write bypass. A multi-cycle context engine saves or restores the whole active register set to or from one of BANKS shadow banks. It sits between the decode/execute stages and the control unit of the multi-cycle core. Control stalls on `ctx_busy`.

## Interface
- `REG_WIDTH`, 16: register width in bits; must be even. HW = REG_WIDTH/2.
- `REG_COUNT`, 8: number of architectural registers, PC included. AW = $clog2(REG_COUNT).
- `RD_PORTS`, 2: number of independent combinational read ports.
- `BANKS`, 2: number of shadow banks. BW = max(1, $clog2(BANKS)).
- `PC_ADDR`, REG_COUNT-1: register index mapped to the internal PC.
- `PC_STEP`, 2: increment applied by `pc_inc`.
- `RESET_PC`, 0: PC value after reset.
- `BYPASS`, 1: 1 = a read of the register being written returns the write data in the same cycle.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `wr_en` in 2: byte-lane write enables. [0] writes the low HW bits, [1] writes the high HW bits.
- `wr_addr` in AW: write index.
- `wr_data` in REG_WIDTH: write data.
- `rd_addr[0:RD_PORTS-1]` in AW each: read indices.
- `rd_size[0:RD_PORTS-1]` in 1 each: 1 = word read, 0 = low byte sign-extended.
- `rd_data[0:RD_PORTS-1]` out REG_WIDTH each: read data.
- `pc_inc` in 1: advance PC by PC_STEP.
- `pc_out` out REG_WIDTH: current PC register value (registered).
- `ctx_req` in 1: start a context operation.
- `ctx_op` in 1: 0 = save active to shadow, 1 = restore shadow to active.
- `ctx_bank` in BW: target shadow bank.
- `ctx_busy` out 1: context engine running.
- `ctx_done` out 1: one-cycle completion pulse.

## Operation
- Storage:
  - Active array act[0:REG_COUNT-1]; entry PC_ADDR is the PC register.
  - Shadow array shd[0:BANKS-1][0:REG_COUNT-1].
- Reset (rst_n=0 at an edge):
  - All act and shd entries are cleared to 0; PC = RESET_PC.
  - FSM goes to IDLE; ctx_busy=0, ctx_done=0.
  - rd_data follows the cleared contents combinationally.
- Write (FSM in IDLE only):
  - Enabled lanes of act[wr_addr] are updated at the edge.
  - Disabled lanes keep their value.
  - Writes presented while ctx_busy=1 are dropped.
- PC update priority at each edge, highest first:
  1. Restore-copy of index PC_ADDR.
  2. CPU write with wr_addr==PC_ADDR and any lane enabled: byte-lane write, no increment that cycle.
  3. pc_inc: PC = PC + PC_STEP, modulo 2^REG_WIDTH; wraps silently.
  - pc_inc is ignored while ctx_busy=1.
- Read, for each port p:
  - src = act[rd_addr[p]].
  - If BYPASS=1 and the FSM is IDLE and wr_addr==rd_addr[p], each enabled lane of src is replaced by the matching wr_data lane.
  - rd_size[p]=1: rd_data[p] = src.
  - rd_size[p]=0: rd_data[p] = {HW{src[HW-1]}, src[HW-1:0]}.
  - PC reads go through the same path.
  - Reads are always valid, including while busy; they show act as it is mid-copy.
- Context FSM states: IDLE, COPY, DONE.
  - IDLE: on ctx_req=1, latch ctx_op and ctx_bank, set index=0, go to COPY.
  - COPY: one entry per cycle, index 0 to REG_COUNT-1.
    - Save: shd[bank][index] <= act[index].
    - Restore: act[index] <= shd[bank][index].
    - After index REG_COUNT-1, go to DONE.
  - DONE: ctx_done=1 for this one cycle, then go to IDLE.
- ctx_req is ignored in COPY and DONE; there is no queueing.
- A ctx_bank value ≥ BANKS selects bank (ctx_bank mod BANKS).
- Reset mid-COPY aborts the operation; there is no partial-completion guarantee.

## Timing
- Read path: combinational from rd_addr, rd_size and (with bypass) wr_*; zero-cycle latency.
- Write and PC: visible on rd_data and pc_out the cycle after the edge.
- Context operation with ctx_req sampled at edge E0:
  - ctx_busy=1 from E0 through E0+REG_COUNT.
  - Entry i is copied at edge E0+1+i.
  - ctx_done=1 from E0+REG_COUNT to E0+REG_COUNT+1, with ctx_busy=0 in that cycle.
  - Total cycles from request to done: REG_COUNT+1.
- In the DONE cycle ctx_busy=0, so CPU writes and pc_inc are accepted again.
- Reset: the outputs above are valid the cycle after the reset edge.

## Test plan
- Reset then read all registers: every rd_data = 0 and pc_out = RESET_PC. Then pc_inc for 3 cycles: pc_out = 6.
- Write 0xA5F0 to r3 with wr_en=2'b01, then 2'b10 with 0x12xx: r3 = 0x12F0. Port 1 with rd_size=0 on r3: 0xFFF0.
- Bypass: write r2=0x1234 with port 0 reading r2 in the same cycle: rd_data[0]=0x1234 before the edge. Write PC=0x0100 with pc_inc=1: pc_out=0x0100, no increment.
- Save bank 1, overwrite r0..r6 with 0xFFFF, restore bank 1: original values are back. ctx_done occurs exactly 9 cycles after the request (REG_COUNT=8).
- Assert a write, pc_inc and a second ctx_req while busy: act is unchanged by the write, PC is unchanged, and no second operation starts.
- Drive rst_n=0 at copy index 4, then release: FSM in IDLE, ctx_busy=0, registers = 0, PC = RESET_PC. PC wrap: PC=0xFFFE plus pc_inc gives 0x0000.
